// File: rtl/dir_button_event_ctrl.sv
// rtl/dir_button_event_ctrl.sv - direction button conditioning and press-event queue.
// Synchronize, debounce and edge-detect four buttons, then queue presses in fixed priority.
module dir_button_event_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        up,
  input  logic                        down,
  input  logic                        right,
  input  logic                        left,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [1:0]                  evt_dir,
  output logic [3:0]                  btn_level,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync;
  logic [CW-1:0] cnt [4];
  logic [3:0]    flip;
  logic [3:0]    press;
  logic [3:0]    pend;
  logic [3:0]    grant;
  logic [1:0]    push_dir;
  logic          push;
  logic          pop;
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Bit index equals the direction code.
  assign raw = {left, right, down, up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync  <= '0;
    end else begin
      sync1 <= raw;
      sync  <= sync1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      flip[i] = (sync[i] != btn_level[i]) && (cnt[i] == CNT_MAX);
    end
  end

  assign press = flip & sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          btn_level[i] <= sync[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Push decision uses the count at cycle start, so a same-cycle pop never frees a slot.
  assign push  = (pend != 4'd0) && (fifo_count < (AW+1)'(FIFO_DEPTH));
  assign grant = push ? (pend & (~pend + 4'd1)) : 4'd0;
  assign pop   = evt_valid && evt_ready;

  always_comb begin
    push_dir = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) push_dir = 2'(i);
    end
  end

  // A press landing on an already pending bit is merged, even if that bit is being granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      pend <= (pend & ~grant) | (press & ~pend);
      if ((press & pend) != 4'd0) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dir;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign evt_valid = (fifo_count != '0);
  assign evt_dir   = mem[rd_ptr];

endmodule

// File: tb/tb_dir_button_event_ctrl.sv
// tb/tb_dir_button_event_ctrl.sv - directed self-checking bench for dir_button_event_ctrl.
module tb_dir_button_event_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b0, down = 1'b0, right = 1'b0, left = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_dir;
  logic [3:0] btn_level;
  logic [2:0] fifo_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  dir_button_event_ctrl #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .right(right), .left(left),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_dir(evt_dir),
    .btn_level(btn_level), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if ({evt_valid, evt_dir, btn_level, fifo_count, overflow} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {evt_valid, evt_dir, btn_level, fifo_count, overflow});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency(input string tag);
    up = 1'b1;
    tick(5);
    checks++;
    if (btn_level !== 4'b0000) begin errors++; $display("FAIL %s_level_early: got %b expected 0000", tag, btn_level); end
    tick();
    checks++;
    if (btn_level !== 4'b0001) begin errors++; $display("FAIL %s_level_edge6: got %b expected 0001", tag, btn_level); end
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_early: got %b expected 0", tag, evt_valid); end
    tick();
    checks++;
    if ({evt_valid, evt_dir, fifo_count} !== {1'b1, 2'd0, 3'd1}) begin
      errors++;
      $display("FAIL %s_event_edge7: got valid=%b dir=%0d count=%0d expected 1/0/1", tag, evt_valid, evt_dir, fifo_count);
    end
    pop_one();
    checks++;
    if ({evt_valid, fifo_count} !== 4'd0) begin
      errors++;
      $display("FAIL %s_after_pop: got valid=%b count=%0d expected 0/0", tag, evt_valid, fifo_count);
    end
    up = 1'b0;
    tick(10);
    checks++;
    if ({evt_valid, fifo_count, btn_level} !== 8'd0) begin
      errors++;
      $display("FAIL %s_single_event: got valid=%b count=%0d level=%b expected 0", tag, evt_valid, fifo_count, btn_level);
    end
  endtask

  task automatic test_glitch();
    int rises = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        down = (c < 3);
        tick();
        if (btn_level[1]) rises++;
      end
    end
    down = 1'b0;
    tick(8);
    checks++;
    if (rises !== 0) begin errors++; $display("FAIL glitch_level: got %0d high samples expected 0", rises); end
    checks++;
    if ({evt_valid, fifo_count, overflow} !== 5'd0) begin
      errors++;
      $display("FAIL glitch_no_event: got valid=%b count=%0d ovf=%b expected 0", evt_valid, fifo_count, overflow);
    end
  endtask

  task automatic fill_all();
    {left, right, down, up} = 4'b1111;
    tick(6);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (fifo_count !== 3'(k)) begin errors++; $display("FAIL fill_count_%0d: got %0d expected %0d", k, fifo_count, k); end
    end
    {left, right, down, up} = 4'b0000;
    tick(8);
  endtask

  task automatic test_simultaneous();
    fill_all();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({evt_valid, evt_dir} !== {1'b1, 2'(d)}) begin
        errors++;
        $display("FAIL simul_order_%0d: got valid=%b dir=%0d expected 1/%0d", d, evt_valid, evt_dir, d);
      end
      pop_one();
    end
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL simul_drained: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_full_overflow();
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd3;
    fill_all();
    left = 1'b1;
    tick(8);
    checks++;
    if ({fifo_count, overflow, btn_level[3]} !== {3'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL full_pending: got count=%0d ovf=%b lvl=%b expected 4/0/1", fifo_count, overflow, btn_level[3]);
    end
    left = 1'b0;
    tick(8);
    left = 1'b1;
    tick(8);
    checks++;
    if ({fifo_count, overflow} !== {3'd4, 1'b1}) begin
      errors++;
      $display("FAIL full_overflow: got count=%0d ovf=%b expected 4/1", fifo_count, overflow);
    end
    checks++;
    if (evt_dir !== 2'd0) begin errors++; $display("FAIL full_head: got %0d expected 0", evt_dir); end
    pop_one();
    checks++;
    if (fifo_count !== 3'd3) begin errors++; $display("FAIL full_pop_no_push: got %0d expected 3", fifo_count); end
    tick();
    checks++;
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d expected 4", fifo_count); end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (evt_dir !== exp_seq[d]) begin errors++; $display("FAIL full_order_%0d: got %0d expected %0d", d, evt_dir, exp_seq[d]); end
      pop_one();
    end
    checks++;
    if ({evt_valid, fifo_count} !== 4'd0) begin
      errors++;
      $display("FAIL full_drained: got valid=%b count=%0d expected 0/0", evt_valid, fifo_count);
    end
    left = 1'b0;
    tick(8);
  endtask

  task automatic test_back_to_back();
    logic [1:0] got [4];
    logic [1:0] exp_seq [4];
    int   n = 0;
    logic prev_valid = 1'b0;
    exp_seq[0] = 2'd2; exp_seq[1] = 2'd0; exp_seq[2] = 2'd3; exp_seq[3] = 2'd1;
    evt_ready = 1'b1;
    for (int t = 0; t < 70; t++) begin
      right = (t < 8);
      up    = (t >= 10 && t < 18);
      left  = (t >= 20 && t < 28);
      down  = (t >= 30 && t < 38);
      tick();
      checks++;
      if (fifo_count > 3'd1) begin errors++; $display("FAIL b2b_count_t%0d: got %0d expected <=1", t, fifo_count); end
      if (evt_valid) begin
        checks++;
        if (prev_valid) begin errors++; $display("FAIL b2b_not_popped_t%0d: got valid twice expected one cycle", t); end
        if (n < 4) got[n] = evt_dir;
        n++;
      end
      prev_valid = evt_valid;
    end
    evt_ready = 1'b0;
    checks++;
    if (n !== 4) begin errors++; $display("FAIL b2b_event_count: got %0d expected 4", n); end
    for (int d = 0; d < 4 && d < n; d++) begin
      checks++;
      if (got[d] !== exp_seq[d]) begin errors++; $display("FAIL b2b_order_%0d: got %0d expected %0d", d, got[d], exp_seq[d]); end
    end
  endtask

  task automatic test_async_reset();
    {right, down, up} = 3'b111;
    for (int k = 1; k <= 10; k++) begin
      if (k == 8) left = 1'b1;
      tick();
    end
    checks++;
    if (fifo_count !== 3'd3) begin errors++; $display("FAIL arst_queued: got %0d expected 3", fifo_count); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({evt_valid, evt_dir, btn_level, fifo_count, overflow} !== 11'd0) begin
      errors++;
      $display("FAIL arst_immediate: got %b expected 0", {evt_valid, evt_dir, btn_level, fifo_count, overflow});
    end
    {left, right, down, up} = 4'b0000;
    tick(3);
    rst = 1'b0;
    tick();
    checks++;
    if ({evt_valid, btn_level, fifo_count, overflow} !== 9'd0) begin
      errors++;
      $display("FAIL arst_release: got %b expected 0", {evt_valid, btn_level, fifo_count, overflow});
    end
    test_latency("arst");
  endtask

  initial begin
    test_reset();
    test_latency("lat");
    test_glitch();
    test_simultaneous();
    test_full_overflow();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
